// File: rtl/perf_counter_pkg.sv
// Shared register-map constants and helpers for the multi-section performance counter.
package perf_counter_pkg;
  localparam logic [1:0] OFF_TIME_LO = 2'd0;
  localparam logic [1:0] OFF_TIME_HI = 2'd1;
  localparam logic [1:0] OFF_EVENT   = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  localparam int ST_OVF = 0;
  localparam int ST_EN  = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/perf_section.sv
// One timed section: enable flop, time and event counters, sticky overflow flag and the
// hi-word shadow that makes 64-bit time reads atomic.
module perf_section #(
  parameter int TIME_WIDTH  = 64,
  parameter int EVENT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        stop,
  input  logic        global_enable,
  input  logic        global_reset,
  input  logic        snap,
  input  logic        ovf_clr,
  output logic        enable,
  output logic [63:0] time_val,
  output logic [31:0] event_val,
  output logic [31:0] shadow,
  output logic        ovf,
  output logic        ovf_next
);
  logic [TIME_WIDTH-1:0]  time_q;
  logic [EVENT_WIDTH-1:0] event_q;
  logic time_inc, event_inc, wrap;

  assign time_inc  = enable & global_enable;
  assign event_inc = go & global_enable;
  assign wrap      = (time_inc & (&time_q)) | (event_inc & (&event_q));
  assign time_val  = 64'(time_q);
  assign event_val = 32'(event_q);

  // A wrap in the same cycle as a software clear keeps the flag set.
  always_comb begin
    ovf_next = ovf;
    if (global_reset)  ovf_next = 1'b0;
    else if (wrap)     ovf_next = 1'b1;
    else if (ovf_clr)  ovf_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable  <= 1'b0;
      time_q  <= '0;
      event_q <= '0;
      ovf     <= 1'b0;
      shadow  <= '0;
    end else begin
      ovf <= ovf_next;
      if (global_reset) begin
        enable  <= 1'b0;
        time_q  <= '0;
        event_q <= '0;
      end else begin
        if (stop)    enable <= 1'b0;
        else if (go) enable <= 1'b1;
        if (time_inc)  time_q  <= time_q + 1'b1;
        if (event_inc) event_q <= event_q + 1'b1;
      end
      // Shadows survive the global reset so a pending hi-word read stays coherent.
      if (snap) shadow <= time_val[63:32];
    end
  end
endmodule

// File: rtl/perf_counter_multi.sv
// Avalon-MM performance counter: address decode, section 0 global gating, read mux,
// registered readdata and overflow interrupt.
module perf_counter_multi
  import perf_counter_pkg::*;
#(
  parameter int NUM_SECTIONS = 4,
  parameter int TIME_WIDTH   = 64,
  parameter int EVENT_WIDTH  = 32,
  parameter int IRQ_ENABLE   = 1,
  localparam int AW          = clog2(4 * NUM_SECTIONS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           address,
  input  logic                    begintransfer,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic [NUM_SECTIONS-1:0] hw_go,
  input  logic [NUM_SECTIONS-1:0] hw_stop,
  output logic                    irq
);
  logic wr, rd, in_range, global_enable, global_reset;
  logic [1:0]  off;
  logic [31:0] addr_ext, rdata_mux;
  logic [NUM_SECTIONS-1:0] sel, go, stop, enable, ovf, ovf_next;
  logic [63:0] time_val  [NUM_SECTIONS];
  logic [31:0] event_val [NUM_SECTIONS];
  logic [31:0] shadow    [NUM_SECTIONS];
  logic        unused_wdata;

  assign wr           = write & begintransfer;
  assign rd           = read & begintransfer;
  assign off          = address[1:0];
  assign addr_ext     = 32'(address);
  assign in_range     = addr_ext < 32'(4 * NUM_SECTIONS);
  assign unused_wdata = &{1'b0, writedata[31:1]};

  assign global_reset  = wr & sel[0] & (off == OFF_TIME_LO) & writedata[0];
  assign global_enable = enable[0] | go[0];

  for (genvar i = 0; i < NUM_SECTIONS; i++) begin : g_sec
    assign sel[i]  = in_range & (addr_ext[31:2] == 30'(i));
    assign go[i]   = (wr & sel[i] & (off == OFF_TIME_HI)) | hw_go[i];
    assign stop[i] = (wr & sel[i] & (off == OFF_TIME_LO)) | hw_stop[i];

    perf_section #(
      .TIME_WIDTH (TIME_WIDTH),
      .EVENT_WIDTH(EVENT_WIDTH)
    ) u_sec (
      .clk          (clk),
      .reset        (reset),
      .go           (go[i]),
      .stop         (stop[i]),
      .global_enable(global_enable),
      .global_reset (global_reset),
      .snap         (rd & sel[i] & (off == OFF_TIME_LO)),
      .ovf_clr      (wr & sel[i] & (off == OFF_STATUS) & writedata[0]),
      .enable       (enable[i]),
      .time_val     (time_val[i]),
      .event_val    (event_val[i]),
      .shadow       (shadow[i]),
      .ovf          (ovf[i]),
      .ovf_next     (ovf_next[i])
    );
  end

  // Mux reads current (pre-write, pre-increment) state; out-of-range addresses select nothing.
  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < NUM_SECTIONS; i++) begin
      if (sel[i]) begin
        case (off)
          OFF_TIME_LO: rdata_mux = time_val[i][31:0];
          OFF_TIME_HI: rdata_mux = shadow[i];
          OFF_EVENT:   rdata_mux = event_val[i];
          default: begin
            rdata_mux[ST_EN]  = enable[i];
            rdata_mux[ST_OVF] = ovf[i];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (rd) readdata <= rdata_mux;
      // Fed from next-state flags so irq tracks the ovf flops cycle for cycle.
      irq <= (IRQ_ENABLE != 0) & (|ovf_next);
    end
  end
endmodule
